// File: rtl/sd_dac_multi.sv
// sd_dac_multi: multi-channel sigma-delta audio DAC, 1st/2nd order, valid/ready sample port
// Ports:
//   Clk, Reset       system clock, asynchronous active-high reset
//   Ce               modulator step strobe
//   In_Valid/Ready   sample-set handshake into a one-deep pending buffer
//   In_Data          CHANNELS packed samples, ch0 in the low WIDTH bits
//   Mute             load mid-scale on every step, hold the pending buffer
//   Underrun         step taken with the pending buffer empty (not while muted)
//   DACout           registered 1-bit modulator outputs, one per channel
module sd_dac_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int ORDER    = 1,
    parameter int SIGNED   = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Ce,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic                      Mute,
    output logic                      Underrun,
    output logic [CHANNELS-1:0]       DACout
);
    localparam int N = CHANNELS * WIDTH;
    localparam logic [N-1:0] MID = {CHANNELS{{1'b1, {(WIDTH-1){1'b0}}}}};

    logic [N-1:0] pend_q, pend_d, act_q, act_d;
    logic         pend_full_q, pend_full_d;
    logic         accept;

    assign In_Ready = ~pend_full_q;
    assign accept   = In_Valid & ~pend_full_q;
    assign Underrun = Ce & ~pend_full_q & ~Mute;

    // Samples are stored as offset codes; the sign flip of every lane is an XOR with MID.
    always_comb begin
        pend_d      = accept ? ((SIGNED != 0) ? In_Data ^ MID : In_Data) : pend_q;
        pend_full_d = accept | (pend_full_q & ~(Ce & ~Mute));
        act_d       = ~Ce ? act_q : Mute ? MID : pend_full_q ? pend_q : act_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= MID;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] u;
        logic             dac_q, dac_d;
        assign u         = act_q[c*WIDTH +: WIDTH];
        assign DACout[c] = dac_q;
        if (ORDER == 1) begin : g_o1
            logic [WIDTH-1:0] acc_q, acc_d;
            logic [WIDTH:0]   sum;
            always_comb begin
                sum   = {1'b0, acc_q} + {1'b0, u};
                acc_d = Ce ? sum[WIDTH-1:0] : acc_q;
                dac_d = Ce ? sum[WIDTH] : dac_q;
            end
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    acc_q <= '0;
                    dac_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    dac_q <= dac_d;
                end
            end
        end else begin : g_o2
            localparam int IW = WIDTH + 4;
            localparam logic signed [IW-1:0] HALF = IW'(1) << (WIDTH - 1);
            logic signed [IW-1:0] s, fb, i1_n, i2_n, i1_q, i1_d, i2_q, i2_d;
            // Both integrators wrap freely; the four guard bits keep them in range for stable inputs.
            always_comb begin
                s     = $signed({4'b0000, u}) - HALF;
                fb    = dac_q ? HALF : -HALF;
                i1_n  = i1_q + s - fb;
                i2_n  = i2_q + i1_n - fb;
                i1_d  = Ce ? i1_n : i1_q;
                i2_d  = Ce ? i2_n : i2_q;
                dac_d = Ce ? ~i2_n[IW-1] : dac_q;
            end
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    i1_q  <= '0;
                    i2_q  <= '0;
                    dac_q <= 1'b0;
                end else begin
                    i1_q  <= i1_d;
                    i2_q  <= i2_d;
                    dac_q <= dac_d;
                end
            end
        end
    end
endmodule
